// File: rtl/mux_scan_pkg.sv
// Shared state type, channel constants and channel-search helper for the mux scan sequencer.
package mux_scan_pkg;

   localparam int unsigned NUM_CH = 4;
   localparam int unsigned SEL_W  = 2;

   typedef enum logic [1:0] {
      StIdle,
      StSettle,
      StSample,
      StHold
   } scan_state_e;

   // Returns {found, index} of the lowest unmasked channel at or above lo.
   function automatic logic [SEL_W:0] next_unmasked(input logic [NUM_CH-1:0] mask, input int lo);
      logic [SEL_W:0] r;
      r = '0;
      for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
         if (i >= lo && !mask[i]) r = {1'b1, SEL_W'(i)};
      end
      return r;
   endfunction

endpackage

// File: rtl/mux_scan_settle_cnt.sv
// Loadable settle down-counter; done is high while the count is zero.
module mux_scan_settle_cnt #(
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   input  logic [CNT_W-1:0] load_val,
   output logic             done
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && !done) begin
         count <= count - 1'b1;
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/mux4_scan_sequencer.sv
// Scans a 4:1 mux channel by channel and offers the sampled 4-bit frame on valid/ready.
// Optional channel skipping via `define MUX_SCAN_MASK_EN (adds the ch_mask port).
module mux4_scan_sequencer
   import mux_scan_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned CNT_W         = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              y,
   output logic              s1,
   output logic              s0,
   output logic              busy,
   output logic [NUM_CH-1:0] frame,
   output logic              frame_valid,
   input  logic              frame_ready,
   output logic              overrun
`ifdef MUX_SCAN_MASK_EN
   ,
   input  logic [NUM_CH-1:0] ch_mask
`endif
);

   scan_state_e       state;
   logic [SEL_W-1:0]  ch;
   logic [NUM_CH-1:0] start_mask;
   logic [NUM_CH-1:0] mask_q;
   logic [SEL_W:0]    start_pick;
   logic [SEL_W:0]    next_pick;
   logic              cnt_load;
   logic              cnt_en;
   logic              cnt_done;

`ifdef MUX_SCAN_MASK_EN
   assign start_mask = ch_mask;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mask_q <= '0;
      end else if (state == StIdle && start) begin
         mask_q <= ch_mask;
      end
   end
`else
   assign start_mask = '0;
   assign mask_q     = '0;
`endif

   always_comb begin
      start_pick = next_unmasked(start_mask, 0);
      next_pick  = next_unmasked(mask_q, int'(ch) + 1);
      cnt_load   = ((state == StIdle) && start && start_pick[SEL_W]) ||
                   ((state == StSample) && next_pick[SEL_W]);
      cnt_en     = (state == StSettle);
   end

   mux_scan_settle_cnt #(
      .CNT_W (CNT_W)
   ) u_settle_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .en       (cnt_en),
      .load_val (CNT_W'(SETTLE_CYCLES - 1)),
      .done     (cnt_done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= StIdle;
         ch          <= '0;
         {s1, s0}    <= '0;
         frame       <= '0;
         frame_valid <= 1'b0;
         busy        <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         unique case (state)
            StIdle: begin
               if (start) begin
                  busy  <= 1'b1;
                  frame <= '0;
                  if (start_pick[SEL_W]) begin
                     state    <= StSettle;
                     ch       <= start_pick[SEL_W-1:0];
                     {s1, s0} <= start_pick[SEL_W-1:0];
                  end else begin
                     // Everything masked: one pass through SAMPLE gives the 1-cycle floor.
                     state    <= StSample;
                     ch       <= '0;
                     {s1, s0} <= '0;
                  end
               end
            end
            StSettle: begin
               if (cnt_done) state <= StSample;
            end
            StSample: begin
               frame[ch] <= y & ~mask_q[ch];
               if (next_pick[SEL_W]) begin
                  state    <= StSettle;
                  ch       <= next_pick[SEL_W-1:0];
                  {s1, s0} <= next_pick[SEL_W-1:0];
               end else begin
                  state       <= StHold;
                  frame_valid <= 1'b1;
               end
            end
            StHold: begin
               if (frame_ready) begin
                  state       <= StIdle;
                  frame_valid <= 1'b0;
                  busy        <= 1'b0;
                  ch          <= '0;
                  {s1, s0}    <= '0;
               end
            end
            default: state <= StIdle;
         endcase

         // A start coinciding with the accepting edge is itself an overrun.
         if (state == StHold && frame_ready) begin
            overrun <= start;
         end else if (state != StIdle && start) begin
            overrun <= 1'b1;
         end
      end
   end

endmodule
